// File: rtl/wb_arb_pkg.sv
// Shared widths, state encoding and counter width for the writeback-port arbiter.
package wb_arb_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int DATA_W       = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {NORMAL = 1'b0, STEAL = 1'b1} arb_state_e;
endpackage

// File: rtl/wb_arb_starve_ctr.sv
// Saturating LU starvation counter; tc flags the last blocked cycle before a steal.
module wb_arb_starve_ctr
  import wb_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic lu_valid,
  input  logic lu_gnt,
  output logic tc
);
  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                  cnt <= '0;
    else if (lu_gnt || !lu_valid)  cnt <= '0;
    else if (cnt != '1)            cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == STARVE_CNT_W'(STARVE_MAX - 1));
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs long-latency unit, with forced steal.
// Define WB_ARB_STATS_EN to add saturating steal / LU-write statistics outputs.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic                  lu_valid_i,
  input  logic [REG_ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0]     lu_data_i,
  output logic                  lu_ready_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0]     rf_data_o,
  output logic                  stall_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]           stat_steal_o,
  output logic [15:0]           stat_lu_grant_o
`endif
);
  arb_state_e state, next_state;
  logic pw, lv, pipe_gnt, lu_gnt, tc;

  always_comb begin
    pw       = wb_we_i && (wb_addr_i != '0);
    lv       = lu_valid_i && (lu_addr_i != '0);
    pipe_gnt = (state == NORMAL) && pw;
    // In STEAL pipe_gnt is 0, so LU wins whenever it is valid.
    lu_gnt     = lu_valid_i && !pipe_gnt;
    lu_ready_o = rst_n_i && lu_gnt;
    rf_we_o    = rst_n_i && (lu_gnt ? lv : pipe_gnt);
    rf_addr_o  = lu_gnt ? lu_addr_i : wb_addr_i;
    rf_data_o  = lu_gnt ? lu_data_i : wb_data_i;
    next_state = NORMAL;
    if (state == NORMAL && lu_valid_i && !lu_gnt && tc) next_state = STEAL;
  end

  wb_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .lu_valid (lu_valid_i),
    .lu_gnt   (lu_gnt),
    .tc       (tc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= NORMAL;
      stall_o <= 1'b0;
    end else begin
      state   <= next_state;
      stall_o <= (next_state == STEAL);
    end
  end

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_steal_o    <= '0;
      stat_lu_grant_o <= '0;
    end else begin
      if (state == STEAL && stat_steal_o != 16'hFFFF)
        stat_steal_o <= stat_steal_o + 1'b1;
      if (lu_gnt && rf_we_o && stat_lu_grant_o != 16'hFFFF)
        stat_lu_grant_o <= stat_lu_grant_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter with a cycle-level behavioural model.
module tb_wb_port_arbiter;
  localparam int STARVE_MAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wb_we_i, lu_valid_i;
  logic [4:0]  wb_addr_i, lu_addr_i;
  logic [31:0] wb_data_i, lu_data_i;
  logic        lu_ready_o, rf_we_o, stall_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o;
`ifdef WB_ARB_STATS_EN
  logic [15:0] stat_steal_o, stat_lu_grant_o;
`endif

  wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .lu_valid_i(lu_valid_i), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
    .lu_ready_o(lu_ready_o), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_data_o(rf_data_o), .stall_o(stall_o)
`ifdef WB_ARB_STATS_EN
    , .stat_steal_o(stat_steal_o), .stat_lu_grant_o(stat_lu_grant_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic        ready;
    logic        stall;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: cycles the current LU result has been refused, and whether
  // this cycle is the stolen one.
  int   waited = 0;
  bit   steal_now = 0;
  bit   hold_wb = 0, hold_lu = 0;
  int   n_steal = 0, n_lu_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every cycle's outputs against the next queued expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("rf_we", {31'd0, rf_we_o}, {31'd0, e.we});
      chk("lu_ready", {31'd0, lu_ready_o}, {31'd0, e.ready});
      chk("stall", {31'd0, stall_o}, {31'd0, e.stall});
      if (e.we) begin
        chk("rf_addr", {27'd0, rf_addr_o}, {27'd0, e.addr});
        chk("rf_data", rf_data_o, e.data);
      end
    end
  end

  // One cycle: pick inputs (respecting MEM/WB hold on stall and LU hold until
  // ready), predict outputs from the arbitration rules, advance the model.
  task automatic step(input bit rst, input int pw_pct, input int lu_pct);
    bit   pw, lv, lu_gnt;
    exp_t e;
    @(posedge clk_i); #1;
    rst_n_i = rst;
    if (!hold_wb) begin
      wb_we_i   = ($urandom_range(99) < pw_pct);
      wb_addr_i = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      wb_data_i = $urandom;
    end
    if (!hold_lu) begin
      lu_valid_i = ($urandom_range(99) < lu_pct);
      lu_addr_i  = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
      lu_data_i  = $urandom;
    end
    if (!rst) begin
      e = '{we: 1'b0, ready: 1'b0, stall: 1'b0, addr: 5'd0, data: 32'd0};
      exp_q.push_back(e);
      steal_now = 0; waited = 0; hold_wb = 0; hold_lu = 0;
      n_steal = 0; n_lu_wr = 0;
      return;
    end
    pw = wb_we_i && (wb_addr_i != 0);
    lv = lu_valid_i && (lu_addr_i != 0);
    lu_gnt = lu_valid_i && (steal_now || !pw);
    e.ready = lu_gnt;
    e.stall = steal_now;
    e.we    = lu_gnt ? lv : (pw && !steal_now);
    e.addr  = lu_gnt ? lu_addr_i : wb_addr_i;
    e.data  = lu_gnt ? lu_data_i : wb_data_i;
    exp_q.push_back(e);
    if (steal_now) n_steal++;
    if (lu_gnt && lv) n_lu_wr++;
    hold_wb = steal_now;
    hold_lu = lu_valid_i && !lu_gnt;
    if (hold_lu) waited++; else waited = 0;
    steal_now = !steal_now && hold_lu && (waited >= STARVE_MAX);
  endtask

  initial begin
    int steal_resets;
    rst_n_i = 0; wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0;
    lu_valid_i = 0; lu_addr_i = 0; lu_data_i = 0;
    repeat (3) step(0, 0, 0);
    // Pipeline only
    repeat (30) step(1, 90, 0);
    // Idle pipeline, LU only
    repeat (30) step(1, 0, 90);
    // Saturated pipeline: LU must be forced through by steals
    repeat (60) step(1, 100, 100);
`ifdef WB_ARB_STATS_EN
    @(posedge clk_i); #2;
    chk("stat_steal", {16'd0, stat_steal_o}, n_steal);
    chk("stat_lu_grant", {16'd0, stat_lu_grant_o}, n_lu_wr);
`endif
    // Reset asserted during a STEAL cycle, several times
    steal_resets = 0;
    for (int i = 0; i < 2000 && steal_resets < 3; i++) begin
      if (steal_now) begin
        step(0, 100, 100);
        steal_resets++;
      end else begin
        step(1, 100, 100);
      end
    end
    chk("steal_reset_seen", steal_resets, 3);
    // Mixed random traffic
    repeat (400) step(1, $urandom_range(100), $urandom_range(100));
    repeat (2) step(1, 0, 0);
`ifdef WB_ARB_STATS_EN
    @(posedge clk_i); #2;
    chk("stat_steal", {16'd0, stat_steal_o}, n_steal);
    chk("stat_lu_grant", {16'd0, stat_lu_grant_o}, n_lu_wr);
`endif
    @(posedge clk_i); #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
